serial_chunk_adder: RTL and testbench

Multi-cycle signed adder/subtractor that processes N-bit operands W bits per clock. The carry is held in a register between chunks. It is the area-reduced, sequential successor to the combinational ripple adder and is used where a full-width carry chain would break timing. It produces Sum, Cout, signed Overflow and Zero, and uses a start/busy/done handshake.

---
 rtl/serial_chunk_adder_if.sv | 27 ++
 rtl/serial_chunk_adder.sv | 124 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
// Handshake and operand/result bundle for serial_chunk_adder.
// The master side issues operations; the slave side is the adder.
interface serial_chunk_adder_if #(
    parameter int N = 32
);
    logic                start;
    logic                Sub;
    logic                Cin;
    logic signed [N-1:0] A;
    logic signed [N-1:0] B;
    logic signed [N-1:0] Sum;
    logic                Cout;
    logic                Overflow;
    logic                Zero;
    logic                Busy;
    logic                Done;

    modport master (
        output start, Sub, Cin, A, B,
        input  Sum, Cout, Overflow, Zero, Busy, Done
    );

    modport slave (
        input  start, Sub, Cin, A, B,
        output Sum, Cout, Overflow, Zero, Busy, Done
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Sequential signed adder/subtractor: adds W bits per clock over K = N/W cycles,
// holding the inter-chunk carry in a register. start/Busy/Done handshake.
module serial_chunk_adder #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_chunk_adder_if.slave    bus
);
    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (W < 1 || (N % W) != 0) begin : g_bad_cfg
        $error("serial_chunk_adder: N must be a non-zero multiple of W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                carry;
    logic signed [N-1:0] a_reg;
    logic signed [N-1:0] b_reg;
    logic signed [N-1:0] part;
    logic signed [N-1:0] next_part;
    logic [W-1:0]        a_chunk;
    logic [W-1:0]        b_chunk;
    logic [W:0]          csum;
    logic                last;
    int                  lsb;

    logic signed [N-1:0] sum_q;
    logic                cout_q;
    logic                ovf_q;
    logic                zero_q;
    logic                busy_q;
    logic                done_q;

    function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                             input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Chunk datapath: one W-bit slice of A and Beff plus the held carry
    always_comb begin
        lsb       = W * int'(cnt);
        a_chunk   = a_reg[lsb +: W];
        b_chunk   = b_reg[lsb +: W];
        csum      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry};
        next_part = part;
        next_part[lsb +: W] = csum[W-1:0];
        last      = (cnt == CW'(K - 1));
    end

    // Operands are pure data captured on the accepting edge; no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            a_reg <= bus.A;
            b_reg <= bus.Sub ? ~bus.B : bus.B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            part   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        carry  <= bus.Sub ? 1'b1 : bus.Cin;
                    end
                end
                RUN: begin
                    part  <= next_part;
                    carry <= csum[W];
                    if (last) begin
                        // Results are published only on the final chunk edge
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        sum_q  <= next_part;
                        cout_q <= csum[W];
                        ovf_q  <= signed_overflow(a_reg[N-1], b_reg[N-1], next_part[N-1]);
                        zero_q <= (next_part == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;
    assign bus.Zero     = zero_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: directed vector table, randomized ops against a
// plain-arithmetic model, and hand-written handshake/reset/degenerate sequences.
module tb_serial_chunk_adder;
    localparam int K = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_chunk_adder_if #(.N(32)) bus ();
    serial_chunk_adder_if #(.N(8))  bus8 ();

    serial_chunk_adder #(.N(32), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    serial_chunk_adder #(.N(8),  .W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: true signed result and unsigned carry/borrow from plain arithmetic
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, output logic [31:0] s, output logic co,
                         output logic ov, output logic z);
        longint sa, sb, r, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        s  = r[31:0];
        co = sub ? (ua >= ub) : (((ua + ub + longint'(cin)) >> 32) != 0);
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        z  = (s == 32'd0);
    endtask

    // Called at posedge+1 with the DUT idle; scrambles inputs after acceptance
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic cin, output logic [31:0] s, output logic co,
                          output logic ov, output logic z, output int busy_n,
                          output int done_n);
        bus.A = a; bus.B = b; bus.Sub = sub; bus.Cin = cin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = $urandom; bus.B = $urandom;
        bus.Sub = 1'($urandom_range(1)); bus.Cin = 1'($urandom_range(1));
        busy_n = 0; done_n = 0; s = '0; co = 1'b0; ov = 1'b0; z = 1'b0;
        for (int i = 0; i < K + 4; i++) begin
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                done_n++;
                s = bus.Sum; co = bus.Cout; ov = bus.Overflow; z = bus.Zero;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic cin, input logic [31:0] es,
                            input logic eco, input logic eov, input logic ez);
        logic [31:0] s;
        logic co, ov, z;
        int bn, dn;
        run_op(a, b, sub, cin, s, co, ov, z, bn, dn);
        check({tag, "_sum"}, 64'(s), 64'(es));
        check({tag, "_cout"}, 64'(co), 64'(eco));
        check({tag, "_ovf"}, 64'(ov), 64'(eov));
        check({tag, "_zero"}, 64'(z), 64'(ez));
        check({tag, "_busy"}, 64'(bn), 64'(K));
        check({tag, "_done"}, 64'(dn), 64'd1);
        check({tag, "_hold"}, 64'($unsigned(bus.Sum)), 64'(es));
    endtask

    initial begin
        logic [31:0] ra, rb, es, s;
        logic        rsub, rcin, eco, eov, ez, co, ov, z;
        logic        prev;
        int          rises[$];
        logic [31:0] sums[$];
        int          dn, bn;
        logic [7:0]  a8[2], b8[2], s8[2];
        logic        sub8[2], ov8[2], co8[2];

        total = 0; bad = 0;
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        bus.start = 1'b0; bus.Sub = 1'b0; bus.Cin = 1'b0; bus.A = '0; bus.B = '0;
        bus8.start = 1'b0; bus8.Sub = 1'b0; bus8.Cin = 1'b0; bus8.A = '0; bus8.B = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #20 rst = 1'b0;
        @(posedge clk); #1;

        check("rst_sum", 64'($unsigned(bus.Sum)), 64'd0);
        check("rst_flags", 64'({bus.Cout, bus.Overflow, bus.Zero, bus.Busy, bus.Done}), 64'd0);
        check("rst_sum8", 64'($unsigned(bus8.Sum)), 64'd0);

        for (int i = 0; i < 7; i++)
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                     vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0: ra = 32'h7FFFFFFF;
                1: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            rb   = ($urandom_range(4) == 0) ? 32'hFFFFFFFF : $urandom;
            rsub = 1'($urandom_range(1));
            rcin = 1'($urandom_range(1));
            model(ra, rb, rsub, rcin, es, eco, eov, ez);
            check_op($sformatf("rnd%0d", i), ra, rb, rsub, rcin, es, eco, eov, ez);
        end

        // start held high: operand changes during RUN must not leak in
        bus.A = 32'd1; bus.B = 32'd1; bus.Sub = 1'b0; bus.Cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.A = 32'd9; bus.B = 32'd9;
        prev = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (bus.Busy && !prev) rises.push_back(c);
            prev = bus.Busy;
            if (bus.Done) sums.push_back(bus.Sum);
            if (c == K + 2) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        check("held_accepts", 64'(rises.size()), 64'd2);
        if (rises.size() >= 2) check("held_gap", 64'(rises[1] - rises[0]), 64'(K + 2));
        check("held_dones", 64'(sums.size()), 64'd2);
        if (sums.size() >= 2) begin
            check("held_sum0", 64'(sums[0]), 64'd2);
            check("held_sum1", 64'(sums[1]), 64'd18);
        end

        // Leave nonzero results behind, then reset during the 3rd RUN cycle
        check_op("pre_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE,
                 1'b1, 1'b0, 1'b0);
        bus.A = 32'h12345678; bus.B = 32'h11111111; bus.Sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_sum", 64'($unsigned(bus.Sum)), 64'd0);
        check("mid_rst_flags", 64'({bus.Cout, bus.Overflow, bus.Zero, bus.Busy, bus.Done}), 64'd0);
        #1 rst = 1'b0;
        dn = 0; bn = 0;
        for (int c = 0; c < K + 4; c++) begin
            @(posedge clk); #1;
            if (bus.Done) dn++;
            if (bus.Busy) bn++;
        end
        check("mid_rst_no_done", 64'(dn), 64'd0);
        check("mid_rst_no_busy", 64'(bn), 64'd0);
        check_op("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Degenerate W == N instance: single-cycle RUN
        a8[0] = 8'h7F; b8[0] = 8'h01; sub8[0] = 1'b0; s8[0] = 8'h80; co8[0] = 1'b0; ov8[0] = 1'b1;
        a8[1] = 8'h80; b8[1] = 8'h01; sub8[1] = 1'b1; s8[1] = 8'h7F; co8[1] = 1'b1; ov8[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            bus8.A = a8[v]; bus8.B = b8[v]; bus8.Sub = sub8[v]; bus8.Cin = 1'b0;
            bus8.start = 1'b1;
            @(posedge clk); #1;
            bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
            bn = 0; dn = 0; s = '0; co = 1'b0; ov = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (bus8.Busy) bn++;
                if (bus8.Done) begin
                    dn++;
                    s = 32'($unsigned(bus8.Sum)); co = bus8.Cout; ov = bus8.Overflow;
                end
                @(posedge clk); #1;
            end
            check($sformatf("n8_%0d_sum", v), 64'(s), 64'(s8[v]));
            check($sformatf("n8_%0d_cout", v), 64'(co), 64'(co8[v]));
            check($sformatf("n8_%0d_ovf", v), 64'(ov), 64'(ov8[v]));
            check($sformatf("n8_%0d_busy", v), 64'(bn), 64'd1);
            check($sformatf("n8_%0d_done", v), 64'(dn), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
